// File: rtl/text_ctrl_pkg.sv
// Shared constants, geometry and state encoding for the text console write controller.
// The optional echo state exists only when TEXT_CTRL_ECHO_EN is defined.
package text_ctrl_pkg;

  localparam int unsigned COLS  = 32;
  localparam int unsigned ROWS  = 4;
  localparam int unsigned COL_W = 5;
  localparam int unsigned ROW_W = 2;
  localparam int unsigned CNT_W = COL_W + ROW_W;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_BS = 8'h08;
  localparam logic [7:0] BLANK    = 8'h20;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_LINE_CLR = 3'd2,
    ST_SCR_CLR  = 3'd3
`ifdef TEXT_CTRL_ECHO_EN
    , ST_ECHO   = 3'd4
`endif
  } state_t;

  // True for bytes that occupy a character cell
  function automatic logic is_printable(input logic [7:0] b);
    return (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

endpackage

// File: rtl/text_clear_seq.sv
// Cell sweep counter for line and full-screen blanking.
// cell_c is the cell issued this cycle when start or advance is high; start
// restarts the sweep at cell 0. done is high while the last cell is on the bus.
module text_clear_seq
  import text_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             advance,
  input  logic             scr,
  output logic [CNT_W-1:0] cell_c,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic             term_c;

  // Current cell and terminal detection for the selected sweep length
  always_comb begin
    cell_c = start ? '0 : cnt_q;
    term_c = scr ? (cell_c == CNT_W'(ROWS * COLS - 1))
                 : (cell_c[COL_W-1:0] == COL_W'(COLS - 1));
  end

  // Counter register and registered terminal flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      done  <= 1'b0;
    end else begin
      done <= (start || advance) && term_c;
      if (start || advance) begin
        cnt_q <= cell_c + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/text_write_ctrl.sv
// Write sequencer for the VGA text console character RAM: interprets received
// bytes, owns the cursor and drives line/screen blanking.
// Define TEXT_CTRL_ECHO_EN to echo each accepted byte to the UART transmitter.
module text_write_ctrl
  import text_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             clear_req,
  input  logic             tx_busy,
  output logic             ram_we,
  output logic [ROW_W-1:0] ram_row,
  output logic [COL_W-1:0] ram_col,
  output logic [7:0]       ram_wdata,
  output logic [ROW_W-1:0] cur_row,
  output logic [COL_W-1:0] cur_col,
  output logic             busy,
  output logic             rx_drop,
  output logic             tx_start,
  output logic [7:0]       tx_data
);

`ifdef TEXT_CTRL_ECHO_EN
  localparam state_t ST_AFTER = ST_ECHO;
`else
  localparam state_t ST_AFTER = ST_IDLE;
`endif

  state_t           state, nxt_state;
  logic [7:0]       byte_q, nxt_byte;
  logic             nxt_we;
  logic [ROW_W-1:0] nxt_row, nxt_cur_row;
  logic [COL_W-1:0] nxt_col, nxt_cur_col;
  logic [7:0]       nxt_wdata;
  logic             seq_start, seq_adv, seq_scr, seq_done;
  logic [CNT_W-1:0] seq_cell_c;
  logic             wrap_c, is_eol_c;

  assign busy     = (state != ST_IDLE);
  assign rx_drop  = rx_valid && (clear_req || (state != ST_IDLE));
  assign wrap_c   = (byte_q != ASCII_BS) && (cur_col == COL_W'(COLS - 1));
  assign is_eol_c = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);

  // Sweep control: clear_req restarts a screen sweep from any state
  always_comb begin
    seq_start = 1'b0;
    seq_adv   = 1'b0;
    seq_scr   = 1'b0;
    if (clear_req) begin
      seq_start = 1'b1;
      seq_scr   = 1'b1;
    end else begin
      case (state)
        ST_IDLE:     seq_start = rx_valid && is_eol_c;
        ST_WRITE:    seq_start = wrap_c;
        ST_LINE_CLR: seq_adv   = !seq_done;
        ST_SCR_CLR: begin
          seq_scr = 1'b1;
          seq_adv = !seq_done;
        end
        default: ;
      endcase
    end
  end

  text_clear_seq u_clear_seq (
    .clk     (clk),
    .reset   (reset),
    .start   (seq_start),
    .advance (seq_adv),
    .scr     (seq_scr),
    .cell_c  (seq_cell_c),
    .done    (seq_done)
  );

`ifdef TEXT_CTRL_ECHO_EN
  logic       nxt_tx_start;
  logic [7:0] nxt_tx_data;
`else
  logic       unused_tx_busy;
  assign unused_tx_busy = tx_busy;
  assign tx_start       = 1'b0;
  assign tx_data        = 8'h00;
`endif

  // Next state, next cursor and next RAM write port values
  always_comb begin
    nxt_state   = state;
    nxt_byte    = byte_q;
    nxt_we      = 1'b0;
    nxt_row     = ram_row;
    nxt_col     = ram_col;
    nxt_wdata   = ram_wdata;
    nxt_cur_row = cur_row;
    nxt_cur_col = cur_col;
`ifdef TEXT_CTRL_ECHO_EN
    nxt_tx_start = 1'b0;
    nxt_tx_data  = tx_data;
`endif
    if (clear_req) begin
      nxt_state = ST_SCR_CLR;
      nxt_we    = 1'b1;
      nxt_row   = seq_cell_c[CNT_W-1:COL_W];
      nxt_col   = seq_cell_c[COL_W-1:0];
      nxt_wdata = BLANK;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            nxt_byte = rx_data;
            if (is_printable(rx_data)) begin
              nxt_state = ST_WRITE;
              nxt_we    = 1'b1;
              nxt_row   = cur_row;
              nxt_col   = cur_col;
              nxt_wdata = rx_data;
            end else if (is_eol_c) begin
              nxt_state   = ST_LINE_CLR;
              nxt_we      = 1'b1;
              nxt_row     = cur_row + ROW_W'(1);
              nxt_col     = seq_cell_c[COL_W-1:0];
              nxt_wdata   = BLANK;
              nxt_cur_row = cur_row + ROW_W'(1);
              nxt_cur_col = '0;
            end else if ((rx_data == ASCII_BS) && (cur_col != '0)) begin
              nxt_state = ST_WRITE;
              nxt_we    = 1'b1;
              nxt_row   = cur_row;
              nxt_col   = cur_col - COL_W'(1);
              nxt_wdata = BLANK;
            end
          end
        end
        ST_WRITE: begin
          if (wrap_c) begin
            nxt_state   = ST_LINE_CLR;
            nxt_we      = 1'b1;
            nxt_row     = cur_row + ROW_W'(1);
            nxt_col     = seq_cell_c[COL_W-1:0];
            nxt_wdata   = BLANK;
            nxt_cur_row = cur_row + ROW_W'(1);
            nxt_cur_col = '0;
          end else begin
            nxt_state   = ST_AFTER;
            nxt_cur_col = (byte_q == ASCII_BS) ? cur_col - COL_W'(1)
                                               : cur_col + COL_W'(1);
          end
        end
        ST_LINE_CLR: begin
          if (seq_done) begin
            nxt_state = ST_AFTER;
          end else begin
            nxt_we    = 1'b1;
            nxt_row   = cur_row;
            nxt_col   = seq_cell_c[COL_W-1:0];
            nxt_wdata = BLANK;
          end
        end
        ST_SCR_CLR: begin
          if (seq_done) begin
            nxt_state   = ST_IDLE;
            nxt_cur_row = '0;
            nxt_cur_col = '0;
          end else begin
            nxt_we    = 1'b1;
            nxt_row   = seq_cell_c[CNT_W-1:COL_W];
            nxt_col   = seq_cell_c[COL_W-1:0];
            nxt_wdata = BLANK;
          end
        end
`ifdef TEXT_CTRL_ECHO_EN
        ST_ECHO: begin
          if (!tx_busy) begin
            nxt_state    = ST_IDLE;
            nxt_tx_start = 1'b1;
            nxt_tx_data  = byte_q;
          end
        end
`endif
        default: nxt_state = ST_IDLE;
      endcase
    end
  end

  // State, cursor and registered RAM port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      byte_q    <= 8'h00;
      ram_we    <= 1'b0;
      ram_row   <= '0;
      ram_col   <= '0;
      ram_wdata <= 8'h00;
      cur_row   <= '0;
      cur_col   <= '0;
    end else begin
      state     <= nxt_state;
      byte_q    <= nxt_byte;
      ram_we    <= nxt_we;
      ram_row   <= nxt_row;
      ram_col   <= nxt_col;
      ram_wdata <= nxt_wdata;
      cur_row   <= nxt_cur_row;
      cur_col   <= nxt_cur_col;
    end
  end

`ifdef TEXT_CTRL_ECHO_EN
  // Registered echo request to the UART transmitter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      tx_start <= nxt_tx_start;
      tx_data  <= nxt_tx_data;
    end
  end
`endif

endmodule

// File: tb/tb_text_write_ctrl.sv
// Directed self-checking bench for text_write_ctrl (COLS=32, ROWS=4).
// Echo scenario is exercised when TEXT_CTRL_ECHO_EN is defined.
module tb_text_write_ctrl;

`ifdef TEXT_CTRL_ECHO_EN
  localparam logic ECHO_ON = 1'b1;
`else
  localparam logic ECHO_ON = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       clear_req;
  logic       tx_busy;
  logic       ram_we;
  logic [1:0] ram_row;
  logic [4:0] ram_col;
  logic [7:0] ram_wdata;
  logic [1:0] cur_row;
  logic [4:0] cur_col;
  logic       busy;
  logic       rx_drop;
  logic       tx_start;
  logic [7:0] tx_data;

  int n_cmp = 0;
  int n_bad = 0;

  text_write_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .clear_req (clear_req),
    .tx_busy   (tx_busy),
    .ram_we    (ram_we),
    .ram_row   (ram_row),
    .ram_col   (ram_col),
    .ram_wdata (ram_wdata),
    .cur_row   (cur_row),
    .cur_col   (cur_col),
    .busy      (busy),
    .rx_drop   (rx_drop),
    .tx_start  (tx_start),
    .tx_data   (tx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse rx_valid for one cycle; returns 1 time unit into the following cycle
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 1000) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; clear_req = 1'b0; tx_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({ram_we, ram_row, ram_col, ram_wdata} !== 16'h0000) begin
      n_bad++; $display("FAIL rst_ram: got %h want 0000", {ram_we, ram_row, ram_col, ram_wdata});
    end
    n_cmp++;
    if ({cur_row, cur_col, busy, rx_drop, tx_start, tx_data} !== 18'h0) begin
      n_bad++; $display("FAIL rst_misc: got %h want 0", {cur_row, cur_col, busy, rx_drop, tx_start, tx_data});
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if ({ram_we, busy} !== 2'b00) begin
      n_bad++; $display("FAIL rst_release: got %b want 00", {ram_we, busy});
    end
  endtask

  task automatic test_printable();
    int n;
    send_byte(8'h41);
    n_cmp++;
    if ({ram_we, ram_row, ram_col, ram_wdata, busy} !== {1'b1, 2'd0, 5'd0, 8'h41, 1'b1}) begin
      n_bad++; $display("FAIL pr_write: got %h want %h", {ram_we, ram_row, ram_col, ram_wdata, busy},
                        {1'b1, 2'd0, 5'd0, 8'h41, 1'b1});
    end
    tick();
    n_cmp++;
    if ({ram_we, cur_row, cur_col, busy, tx_start} !== {1'b0, 2'd0, 5'd1, ECHO_ON, 1'b0}) begin
      n_bad++; $display("FAIL pr_after: got %b want %b", {ram_we, cur_row, cur_col, busy, tx_start},
                        {1'b0, 2'd0, 5'd1, ECHO_ON, 1'b0});
    end
    wait_idle(n);
  endtask

  task automatic test_wrap();
    int n;
    int bad;
    for (int i = 0; i < 30; i++) begin
      send_byte(8'h61);
      wait_idle(n);
    end
    n_cmp++;
    if ({cur_row, cur_col} !== {2'd0, 5'd31}) begin
      n_bad++; $display("FAIL wrap_pos: got (%0d,%0d) want (0,31)", cur_row, cur_col);
    end
    send_byte(8'h42);
    n_cmp++;
    if ({ram_we, ram_row, ram_col, ram_wdata, cur_col} !== {1'b1, 2'd0, 5'd31, 8'h42, 5'd31}) begin
      n_bad++; $display("FAIL wrap_write: got %h want %h", {ram_we, ram_row, ram_col, ram_wdata, cur_col},
                        {1'b1, 2'd0, 5'd31, 8'h42, 5'd31});
    end
    tick();
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if ({ram_we, ram_row, ram_col, ram_wdata} !== {1'b1, 2'd1, 5'(i), 8'h20}) bad++;
      tick();
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++; $display("FAIL wrap_lineclr: got %0d bad cells want 0", bad);
    end
    n_cmp++;
    if ({ram_we, cur_row, cur_col, busy} !== {1'b0, 2'd1, 5'd0, ECHO_ON}) begin
      n_bad++; $display("FAIL wrap_end: got %b want %b", {ram_we, cur_row, cur_col, busy},
                        {1'b0, 2'd1, 5'd0, ECHO_ON});
    end
    wait_idle(n);
  endtask

  task automatic test_crlf();
    int n;
    int bad;
    send_byte(8'h0D); wait_idle(n);
    send_byte(8'h0D); wait_idle(n);
    for (int i = 0; i < 5; i++) begin
      send_byte(8'h61); wait_idle(n);
    end
    n_cmp++;
    if ({cur_row, cur_col} !== {2'd3, 5'd5}) begin
      n_bad++; $display("FAIL cr_pos: got (%0d,%0d) want (3,5)", cur_row, cur_col);
    end
    send_byte(8'h0D);
    n_cmp++;
    if ({cur_row, cur_col, busy} !== {2'd0, 5'd0, 1'b1}) begin
      n_bad++; $display("FAIL cr_cursor: got %b want %b", {cur_row, cur_col, busy}, {2'd0, 5'd0, 1'b1});
    end
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if ({ram_we, ram_row, ram_col, ram_wdata} !== {1'b1, 2'd0, 5'(i), 8'h20}) bad++;
      tick();
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++; $display("FAIL cr_lineclr: got %0d bad cells want 0", bad);
    end
    n_cmp++;
    if (ram_we !== 1'b0) begin
      n_bad++; $display("FAIL cr_end_we: got %b want 0", ram_we);
    end
    wait_idle(n);
  endtask

  task automatic test_backspace();
    int n;
    send_byte(8'h0A); wait_idle(n);
    send_byte(8'h0A); wait_idle(n);
    send_byte(8'h08);
    n_cmp++;
    if ({ram_we, busy, cur_row, cur_col} !== {1'b0, 1'b0, 2'd2, 5'd0}) begin
      n_bad++; $display("FAIL bs_col0: got %b want %b", {ram_we, busy, cur_row, cur_col},
                        {1'b0, 1'b0, 2'd2, 5'd0});
    end
    for (int i = 0; i < 7; i++) begin
      send_byte(8'h61); wait_idle(n);
    end
    send_byte(8'h08);
    n_cmp++;
    if ({ram_we, ram_row, ram_col, ram_wdata, cur_col} !== {1'b1, 2'd2, 5'd6, 8'h20, 5'd7}) begin
      n_bad++; $display("FAIL bs_write: got %h want %h", {ram_we, ram_row, ram_col, ram_wdata, cur_col},
                        {1'b1, 2'd2, 5'd6, 8'h20, 5'd7});
    end
    tick();
    n_cmp++;
    if ({ram_we, cur_row, cur_col} !== {1'b0, 2'd2, 5'd6}) begin
      n_bad++; $display("FAIL bs_cursor: got %b want %b", {ram_we, cur_row, cur_col}, {1'b0, 2'd2, 5'd6});
    end
    wait_idle(n);
  endtask

  task automatic test_ignored();
    send_byte(8'h07);
    n_cmp++;
    if ({ram_we, busy, cur_row, cur_col} !== {1'b0, 1'b0, 2'd2, 5'd6}) begin
      n_bad++; $display("FAIL ign: got %b want %b", {ram_we, busy, cur_row, cur_col},
                        {1'b0, 1'b0, 2'd2, 5'd6});
    end
  endtask

  task automatic test_clear_abort();
    int bad;
    send_byte(8'h0D);
    repeat (4) tick();
    clear_req = 1'b1;
    rx_valid  = 1'b1;
    rx_data   = 8'h55;
    #1;
    n_cmp++;
    if (rx_drop !== 1'b1) begin
      n_bad++; $display("FAIL clr_drop_same: got %b want 1", rx_drop);
    end
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    rx_valid  = 1'b0;
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      if ({ram_we, ram_row, ram_col, ram_wdata} !== {1'b1, 2'(i >> 5), 5'(i), 8'h20}) bad++;
      if (i == 10) begin
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        #1;
        n_cmp++;
        if (rx_drop !== 1'b1) begin
          n_bad++; $display("FAIL clr_drop_busy: got %b want 1", rx_drop);
        end
      end
      tick();
      rx_valid = 1'b0;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++; $display("FAIL clr_cells: got %0d bad cells want 0", bad);
    end
    n_cmp++;
    if ({ram_we, busy, cur_row, cur_col} !== 9'b0) begin
      n_bad++; $display("FAIL clr_end: got %b want 0", {ram_we, busy, cur_row, cur_col});
    end
  endtask

  task automatic test_back_to_back();
    int n;
    send_byte(8'h41);
    rx_valid = 1'b1;
    rx_data  = 8'h42;
    #1;
    n_cmp++;
    if (rx_drop !== 1'b1) begin
      n_bad++; $display("FAIL b2b_drop: got %b want 1", rx_drop);
    end
    tick();
    rx_valid = 1'b0;
    n_cmp++;
    if ({ram_we, cur_col} !== {1'b0, 5'd1}) begin
      n_bad++; $display("FAIL b2b_after: got %b want %b", {ram_we, cur_col}, {1'b0, 5'd1});
    end
    wait_idle(n);
    send_byte(8'h43);
    n_cmp++;
    if ({ram_we, ram_row, ram_col, ram_wdata} !== {1'b1, 2'd0, 5'd1, 8'h43}) begin
      n_bad++; $display("FAIL b2b_next: got %h want %h", {ram_we, ram_row, ram_col, ram_wdata},
                        {1'b1, 2'd0, 5'd1, 8'h43});
    end
    wait_idle(n);
  endtask

  task automatic test_echo();
    int n;
    int bad;
    tx_busy = 1'b1;
    send_byte(8'h41);
    n_cmp++;
    if ({ram_we, ram_wdata} !== {1'b1, 8'h41}) begin
      n_bad++; $display("FAIL echo_write: got %h want %h", {ram_we, ram_wdata}, {1'b1, 8'h41});
    end
    tick();
`ifdef TEXT_CTRL_ECHO_EN
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if ({tx_start, busy} !== 2'b01) bad++;
      tick();
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++; $display("FAIL echo_hold: got %0d bad cycles want 0", bad);
    end
    tx_busy = 1'b0;
    tick();
    n_cmp++;
    if ({tx_start, tx_data, busy} !== {1'b1, 8'h41, 1'b0}) begin
      n_bad++; $display("FAIL echo_pulse: got %h want %h", {tx_start, tx_data, busy}, {1'b1, 8'h41, 1'b0});
    end
    tick();
    n_cmp++;
    if (tx_start !== 1'b0) begin
      n_bad++; $display("FAIL echo_end: got %b want 0", tx_start);
    end
`else
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if ({tx_start, tx_data, busy} !== 10'b0) bad++;
      tick();
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++; $display("FAIL noecho: got %0d bad cycles want 0", bad);
    end
`endif
    tx_busy = 1'b0;
    wait_idle(n);
  endtask

  initial begin
    test_reset();
    test_printable();
    test_wrap();
    test_crlf();
    test_backspace();
    test_ignored();
    test_clear_abort();
    test_back_to_back();
    test_echo();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
